shift_mult_ctrl: RTL and testbench

Sequencer for the serial shift multiplier. It clears and fills the two serial operand shifters (X and Y, each W bits, each with a shift enable and a full flag) and runs an unsigned shift-add multiply over W cycles. It then streams the 2W-bit product out MSB-first and pulses `done`. It sits between the serial operand front-end and any downstream serial consumer.

---
 rtl/shift_mult_ctrl_if.sv | 31 +++
 rtl/shift_mult_ctrl.sv | 156 +++++++++++++++
 tb/tb_shift_mult_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/shift_mult_ctrl_if.sv
// Handshake/bus bundle for the serial shift multiplier sequencer.
// Parameter W: operand width (product width PW = 2*W).
// master modport: operand front-end / bench side (drives start, flags, parallel contents).
// slave modport:  shift_mult_ctrl side (drives clear, shift enables, product stream).
interface shift_mult_ctrl_if #(parameter int W = 11);
    localparam int PW = 2 * W;

    logic          start;
    logic          fx;
    logic          fy;
    logic [W-1:0]  x_par;
    logic [W-1:0]  y_par;
    logic          op_clr;
    logic          sx;
    logic          sy;
    logic          busy;
    logic [PW-1:0] product;
    logic          p_out;
    logic          p_valid;
    logic          done;

    modport master (
        output start, fx, fy, x_par, y_par,
        input  op_clr, sx, sy, busy, product, p_out, p_valid, done
    );

    modport slave (
        input  start, fx, fy, x_par, y_par,
        output op_clr, sx, sy, busy, product, p_out, p_valid, done
    );
endinterface

// File: rtl/shift_mult_ctrl.sv
// Sequencer for the serial shift multiplier: clears and fills the X/Y operand
// shifters, runs a W-cycle unsigned shift-add multiply, streams the 2W-bit
// product out MSB-first and pulses done.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   bus      shift_mult_ctrl_if.slave
//            in : start, fx, fy, x_par[W-1:0], y_par[W-1:0]
//            out: op_clr, sx, sy, busy, product[2W-1:0], p_out, p_valid, done
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start, all strobes low
// S_CLEAR | one-cycle op_clr pulse to both shifters
// S_LOAD  | shift operands in until both full flags are high
// S_MULT  | W shift-add iterations on P
// S_SHOUT | stream product MSB-first, 2W cycles
// S_DONE  | one-cycle done pulse
module shift_mult_ctrl #(
    parameter int W = 11
) (
    input  logic              clk,
    input  logic              rst,
    shift_mult_ctrl_if.slave  bus
);
    localparam int PW = 2 * W;
    localparam int CW = $clog2(PW + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_MULT,
        S_SHOUT,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   p_reg;
    logic [PW-1:0]   product_q;
    logic [W-1:0]    mcand;
    logic [CW-1:0]   cnt;
    logic [W:0]      sum;
    logic [PW-1:0]   p_step;
    logic            mult_last;
    logic            shout_last;
    logic            load_ready;

    // The carry out of the upper-half add becomes the new MSB after the shift.
    always_comb begin
        sum    = {1'b0, p_reg[PW-1:W]} + (p_reg[0] ? {1'b0, mcand} : {(W+1){1'b0}});
        p_step = {sum, p_reg[W-1:1]};
    end

    // cnt counts up through MULT, then is reloaded and counts down through SHOUT
    // so that it doubles as the product bit index.
    assign mult_last  = (cnt == CW'(W - 1));
    assign shout_last = (cnt == '0);
    assign load_ready = bus.fx && bus.fy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bus.op_clr  = 1'b0;
        bus.sx      = 1'b0;
        bus.sy      = 1'b0;
        bus.busy    = 1'b1;
        bus.p_valid = 1'b0;
        bus.p_out   = 1'b0;
        bus.done    = 1'b0;
        case (state)
            S_IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) begin
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                bus.op_clr = 1'b1;
                state_nxt  = S_LOAD;
            end
            S_LOAD: begin
                // Each shifter stops on its own flag.
                bus.sx = !bus.fx;
                bus.sy = !bus.fy;
                if (load_ready) begin
                    state_nxt = S_MULT;
                end
            end
            S_MULT: begin
                if (mult_last) begin
                    state_nxt = S_SHOUT;
                end
            end
            S_SHOUT: begin
                bus.p_valid = 1'b1;
                bus.p_out   = product_q[cnt];
                if (shout_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                bus.done  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_reg     <= '0;
            product_q <= '0;
            mcand     <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (load_ready) begin
                        mcand <= bus.x_par;
                        p_reg <= {{W{1'b0}}, bus.y_par};
                        cnt   <= '0;
                    end
                end
                S_MULT: begin
                    p_reg <= p_step;
                    if (mult_last) begin
                        product_q <= p_step;
                        cnt       <= CW'(PW - 1);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_SHOUT: begin
                    if (!shout_last) begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.product = product_q;
endmodule

// File: tb/tb_shift_mult_ctrl.sv
// Self-checking bench for shift_mult_ctrl: a table of multiply vectors run
// through a behavioural model of the two operand shifters, plus a hand-written
// reset-abort sequence.
module tb_shift_mult_ctrl;
    localparam int W  = 11;
    localparam int PW = 2 * W;

    logic clk;
    logic rst;

    shift_mult_ctrl_if #(.W(W)) bus ();

    shift_mult_ctrl #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Operand shifter model state.
    logic [W-1:0] xv, yv;
    logic [W-1:0] xsr, ysr;
    int           xc, yc, y_extra;

    // Outputs sampled mid-cycle by step().
    logic          o_op_clr, o_sx, o_sy, o_busy, o_p_out, o_p_valid, o_done;
    logic [PW-1:0] o_product;

    typedef struct {
        logic [W-1:0]  x;
        logic [W-1:0]  y;
        logic [PW-1:0] expp;
        int            extra;
        int            s1;
        int            s2;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sample the current cycle at the falling edge, then advance one clock and
    // update the shifter model from what was sampled.
    task automatic step();
        @(negedge clk);
        o_op_clr  = bus.op_clr;
        o_sx      = bus.sx;
        o_sy      = bus.sy;
        o_busy    = bus.busy;
        o_p_out   = bus.p_out;
        o_p_valid = bus.p_valid;
        o_done    = bus.done;
        o_product = bus.product;
        @(posedge clk);
        #1;
        if (o_op_clr) begin
            xsr = '0; xc = 0;
            ysr = '0; yc = 0;
        end else begin
            if (o_sx && xc < W) begin
                xsr = {xsr[W-2:0], xv[W-1-xc]};
                xc++;
            end
            if (o_sy) begin
                if (yc < W) ysr = {ysr[W-2:0], yv[W-1-yc]};
                if (yc < W + y_extra) yc++;
            end
        end
        bus.fx    = (xc >= W);
        bus.fy    = (yc >= W + y_extra);
        bus.x_par = xsr;
        bus.y_par = ysr;
    endtask

    task automatic run(input int idx, input vec_t v);
        int            done_cyc    = -1;
        int            ndone       = 0;
        int            nvalid      = 0;
        int            first_valid = -1;
        int            nsx         = 0;
        int            nsy         = 0;
        int            busy_falls  = 0;
        int            clr_cyc     = -1;
        logic          prev_busy   = 1'b0;
        logic [PW-1:0] stream      = '0;
        logic [PW-1:0] prod_at     = '0;
        string         t;
        xv      = v.x;
        yv      = v.y;
        y_extra = v.extra;
        for (int c = 0; c < 200; c++) begin
            bus.start = (c == 0) || (c == v.s1) || (c == v.s2);
            step();
            if (o_op_clr && clr_cyc < 0) clr_cyc = c;
            if (o_sx) nsx++;
            if (o_sy) nsy++;
            if (o_p_valid) begin
                if (first_valid < 0) first_valid = c;
                stream = {stream[PW-2:0], o_p_out};
                nvalid++;
            end
            if (c == 2*W + 3 + v.extra) prod_at = o_product;
            if (o_done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (prev_busy && !o_busy) busy_falls++;
            prev_busy = o_busy;
            if (done_cyc >= 0 && c >= done_cyc + 4) break;
        end
        bus.start = 1'b0;
        t = $sformatf("v%0d", idx);
        chk({t, " clr_cycle"},   64'(clr_cyc),     64'(1));
        chk({t, " sx_count"},    64'(nsx),         64'(W));
        chk({t, " sy_count"},    64'(nsy),         64'(W + v.extra));
        chk({t, " product"},     64'(prod_at),     64'(v.expp));
        chk({t, " first_valid"}, 64'(first_valid), 64'(2*W + 3 + v.extra));
        chk({t, " valid_count"}, 64'(nvalid),      64'(PW));
        chk({t, " stream"},      64'(stream),      64'(v.expp));
        chk({t, " done_cycle"},  64'(done_cyc),    64'(4*W + 3 + v.extra));
        chk({t, " done_count"},  64'(ndone),       64'(1));
        chk({t, " busy_falls"},  64'(busy_falls),  64'(1));
        chk({t, " idle_after"},  64'(o_busy),      64'(0));
    endtask

    initial begin
        vecs[0] = '{x: 11'd3,    y: 11'd5,    expp: 22'h00000F, extra: 0, s1: -1,     s2: -1};
        vecs[1] = '{x: 11'd2047, y: 11'd2047, expp: 22'h3FF001, extra: 0, s1: -1,     s2: -1};
        vecs[2] = '{x: 11'd0,    y: 11'd1234, expp: 22'h000000, extra: 0, s1: -1,     s2: -1};
        vecs[3] = '{x: 11'd1234, y: 11'd0,    expp: 22'h000000, extra: 0, s1: -1,     s2: -1};
        vecs[4] = '{x: 11'd3,    y: 11'd5,    expp: 22'h00000F, extra: 5, s1: -1,     s2: -1};
        vecs[5] = '{x: 11'd1000, y: 11'd37,   expp: 22'h009088, extra: 0, s1: 2*W,    s2: 4*W+3};
        vecs[6] = '{x: 11'd1024, y: 11'd2047, expp: 22'h1FFC00, extra: 0, s1: -1,     s2: -1};
        vecs[7] = '{x: 11'd1,    y: 11'd1,    expp: 22'h000001, extra: 0, s1: -1,     s2: -1};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.fx    = 1'b0;
        bus.fy    = 1'b0;
        bus.x_par = '0;
        bus.y_par = '0;
        xv = '0; yv = '0; xsr = '0; ysr = '0;
        xc = 0; yc = 0; y_extra = 0;

        step();
        step();
        rst = 1'b0;
        step();
        chk("reset strobes", 64'({o_busy, o_op_clr, o_sx, o_sy, o_p_valid, o_p_out, o_done}), 64'(0));
        chk("reset product", 64'(o_product), 64'(0));

        for (int i = 0; i < 8; i++) begin
            run(i, vecs[i]);
        end

        // Abort in the middle of MULT with start asserted alongside rst.
        xv = 11'd2047; yv = 11'd3; y_extra = 0;
        for (int c = 0; c < W + 6; c++) begin
            bus.start = (c == 0);
            step();
        end
        chk("abort in_mult", 64'(o_busy), 64'(1));
        rst       = 1'b1;
        bus.start = 1'b1;
        step();
        rst       = 1'b0;
        bus.start = 1'b0;
        step();
        chk("abort strobes", 64'({o_busy, o_op_clr, o_sx, o_sy, o_p_valid, o_p_out, o_done}), 64'(0));
        chk("abort product", 64'(o_product), 64'(0));
        begin
            int nd = 0;
            int nb = 0;
            for (int c = 0; c < 60; c++) begin
                step();
                if (o_done) nd++;
                if (o_busy) nb++;
            end
            chk("abort no_done", 64'(nd), 64'(0));
            chk("abort stays_idle", 64'(nb), 64'(0));
        end

        begin
            vec_t v;
            v = '{x: 11'd2047, y: 11'd3, expp: 22'h0017FD, extra: 0, s1: -1, s2: -1};
            run(8, v);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
